// File: rtl/jeff_serial_pkg.sv
// Shared definitions for the jeff serial link (transmitter and future receiver):
// FSM state encodings, frame data width and a baud-counter width helper.
package jeff_serial_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // Counter width for a bit period of clks cycles, never less than one bit.
    function automatic int unsigned baud_cnt_width(input int unsigned clks);
        return (clks > 2) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/jeff_baud_tick.sv
// Bit-period timer: counts clock cycles and emits a one-cycle tick on the last
// cycle of each bit period. clear holds the count at zero so a bit period
// starts cleanly on the cycle after clear drops.
module jeff_baud_tick
    import jeff_serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = baud_cnt_width(CLKS_PER_BIT);
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Tick on the last cycle of a period; the counter wraps so the next bit starts at 0.
    always_comb begin
        tick  = (cnt_q == LastCnt);
        cnt_d = (clear || tick) ? '0 : cnt_q + CntW'(1);
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/jeff_serial_tx_8bit.sv
// 8-bit parallel-in, serial-out frame transmitter.
// Frame: start(0), 8 data bits LSB first, optional even parity, stop(1).
// Build option: define JEFF_SERIAL_TX_PARITY_EN to insert the parity bit.
module jeff_serial_tx_8bit
    import jeff_serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       load_valid,
    output logic       load_ready,
    output logic       sdo,
    output logic       busy,
    output logic       done
);

    localparam int unsigned BitCntW = $clog2(DATA_BITS);
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_BITS - 1);

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q;
    logic [BitCntW-1:0]   bitcnt_q;
    logic                 done_q;
    logic                 tick;
    logic                 load;
`ifdef JEFF_SERIAL_TX_PARITY_EN
    logic                 parity_q;
`endif

    assign load = load_valid && load_ready;

    // Counter is held clear in IDLE so START gets a full bit period after the handshake.
    jeff_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == ST_IDLE),
        .tick  (tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: each non-idle state advances on the bit-period tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (load_valid) state_d = ST_START;
            ST_START: if (tick) state_d = ST_DATA;
            ST_DATA: begin
                if (tick && (bitcnt_q == LastBit)) begin
`ifdef JEFF_SERIAL_TX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef JEFF_SERIAL_TX_PARITY_EN
            ST_PARITY: if (tick) state_d = ST_STOP;
`endif
            ST_STOP:  if (tick) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath: byte capture, shifting, bit counting and the registered done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q  <= '0;
            bitcnt_q <= '0;
            done_q   <= 1'b0;
`ifdef JEFF_SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            done_q <= (state_q == ST_STOP) && tick;
            if (load) begin
                shreg_q  <= data_in;
                bitcnt_q <= '0;
`ifdef JEFF_SERIAL_TX_PARITY_EN
                parity_q <= ^data_in;
`endif
            end else if ((state_q == ST_DATA) && tick) begin
                shreg_q  <= shreg_q >> 1;
                bitcnt_q <= bitcnt_q + BitCntW'(1);
            end
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        load_ready = (state_q == ST_IDLE);
        busy       = (state_q != ST_IDLE);
        done       = done_q;
        case (state_q)
            ST_START:  sdo = 1'b0;
            ST_DATA:   sdo = shreg_q[0];
`ifdef JEFF_SERIAL_TX_PARITY_EN
            ST_PARITY: sdo = parity_q;
`endif
            default:   sdo = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_jeff_serial_tx_8bit.sv
// Scoreboard bench for jeff_serial_tx_8bit. Two DUTs share the stimulus, one with a
// multi-cycle bit period and one with CLKS_PER_BIT=1. A model pushes the expected
// per-cycle line image of each accepted frame into a queue; a monitor on the
// falling edge pops and compares every cycle.
module tb_jeff_serial_tx_8bit;

`ifdef JEFF_SERIAL_TX_PARITY_EN
    localparam int CPB_A = 2;
    localparam int NBITS = 11;
`else
    localparam int CPB_A = 4;
    localparam int NBITS = 10;
`endif
    localparam int CPB_B = 1;

    typedef struct packed {
        logic sdo;
        logic busy;
        logic done;
    } exp_t;

    localparam exp_t IDLE_EXP = '{sdo: 1'b1, busy: 1'b0, done: 1'b0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       mon_en = 1'b0;

    logic sdo0, busy0, done0, ready0;
    logic sdo1, busy1, done1, ready1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    jeff_serial_tx_8bit #(.CLKS_PER_BIT(CPB_A)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (ready0),
        .sdo        (sdo0),
        .busy       (busy0),
        .done       (done0)
    );

    jeff_serial_tx_8bit #(.CLKS_PER_BIT(CPB_B)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (ready1),
        .sdo        (sdo1),
        .busy       (busy1),
        .done       (done1)
    );

    always #5 clk = ~clk;

    // Line bits in transmit order: start, data LSB first, [parity], stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic [10:0] f;
        f = {2'b11, b, 1'b0};
`ifdef JEFF_SERIAL_TX_PARITY_EN
        f[9] = ^b;
`endif
        return f;
    endfunction

    // Reference model: a transmitter with nothing queued accepts the byte; the frame
    // occupies NBITS*CPB cycles, then one idle cycle carries the done pulse.
    always @(posedge clk) begin
        logic [10:0] f;
        if (rst) begin
            q0.delete();
            q1.delete();
        end else if (load_valid) begin
            f = frame_bits(data_in);
            if (q0.size() == 0) begin
                for (int b = 0; b < NBITS; b++)
                    for (int c = 0; c < CPB_A; c++)
                        q0.push_back('{sdo: f[b], busy: 1'b1, done: 1'b0});
                q0.push_back('{sdo: 1'b1, busy: 1'b0, done: 1'b1});
            end
            if (q1.size() == 0) begin
                for (int b = 0; b < NBITS; b++)
                    for (int c = 0; c < CPB_B; c++)
                        q1.push_back('{sdo: f[b], busy: 1'b1, done: 1'b0});
                q1.push_back('{sdo: 1'b1, busy: 1'b0, done: 1'b1});
            end
        end
    end

    task automatic check(input string nm, input int inst, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cycle %0d: got %b expected %b", nm, inst, cyc, act, exp);
        end
    endtask

    // Monitor: one expected entry per cycle, idle when the queue is empty.
    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            e0 = IDLE_EXP;
            e1 = IDLE_EXP;
            if (q0.size() != 0) e0 = q0.pop_front();
            if (q1.size() != 0) e1 = q1.pop_front();
            check("sdo", 0, sdo0, e0.sdo);
            check("busy", 0, busy0, e0.busy);
            check("done", 0, done0, e0.done);
            check("load_ready", 0, ready0, !e0.busy);
            check("sdo", 1, sdo1, e1.sdo);
            check("busy", 1, busy1, e1.busy);
            check("done", 1, done1, e1.done);
            check("load_ready", 1, ready1, !e1.busy);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        load_valid = 1'b1;
        data_in    = b;
        wait_cycles(1);
        load_valid = 1'b0;
        wait_cycles(gap);
    endtask

    initial begin
        // Reset held three edges with a byte offered; nothing may be accepted.
        rst        = 1'b1;
        load_valid = 1'b1;
        data_in    = 8'hFF;
        wait_cycles(1);
        mon_en = 1'b1;
        wait_cycles(2);
        rst        = 1'b0;
        load_valid = 1'b0;
        data_in    = 8'h00;
        wait_cycles(3);

        send(8'hA5, 50);
        send(8'h07, 50);

        // Back-to-back with load_valid held high.
        load_valid = 1'b1;
        data_in    = 8'h00;
        wait_cycles(1);
        data_in = 8'hFF;
        wait_cycles(12);
        load_valid = 1'b0;
        wait_cycles(50);

        // Data changes after the handshake must not reach the line.
        load_valid = 1'b1;
        data_in    = 8'h3C;
        wait_cycles(1);
        load_valid = 1'b0;
        data_in    = 8'hC3;
        wait_cycles(50);

        // Reset in the middle of a frame, then a clean frame.
        send(8'h81, 17);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        send(8'h55, 50);

        // Reset and load together: reset wins.
        rst        = 1'b1;
        load_valid = 1'b1;
        data_in    = 8'h5A;
        wait_cycles(1);
        rst        = 1'b0;
        load_valid = 1'b0;
        wait_cycles(2);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            load_valid = ($urandom_range(0, 3) != 0);
            data_in    = 8'($urandom);
            wait_cycles(1);
        end
        rst        = 1'b0;
        load_valid = 1'b0;
        wait_cycles(60);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
